// File: rtl/ctrl_pipeline.sv
// rtl/ctrl_pipeline.sv - ID/EX, EX/MEM, MEM/WB control registers with load-use stall, branch flush and forwarding
module ctrl_pipeline #(
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic              id_branch,
  input  logic              id_mem_read,
  input  logic              id_mem_to_reg,
  input  logic              id_mem_write,
  input  logic              id_alu_src,
  input  logic              id_reg_write,
  input  logic [1:0]        id_alu_op,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_zero,
  output logic [1:0]        ex_alu_op,
  output logic              ex_alu_src,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              mem_mem_read,
  output logic              mem_mem_write,
  output logic              pc_src,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [REG_AW-1:0] wb_rd,
  output logic              stall,
  output logic              flush
);

  logic              ex_v, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src_q, ex_reg_write;
  logic [1:0]        ex_alu_op_q;
  logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;

  logic              mem_v, mem_branch, mem_mem_read_q, mem_mem_write_q, mem_mem_to_reg, mem_reg_write, mem_zero;
  logic [REG_AW-1:0] mem_rd;

  logic              wb_v, wb_reg_write_q, wb_mem_to_reg_q;
  logic [REG_AW-1:0] wb_rd_q;

  logic uses_rs2, load_use, branch_taken;
  logic mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;

  always_comb begin
    uses_rs2     = !id_alu_src | id_mem_write;
    load_use     = ex_v & ex_mem_read & (ex_rd != '0) & id_valid &
                   ((ex_rd == id_rs1) | (uses_rs2 & (ex_rd == id_rs2)));
    branch_taken = mem_v & mem_branch & mem_zero;
  end

  // A taken branch squashes whatever would have stalled, so flush wins.
  assign flush  = branch_taken;
  assign pc_src = branch_taken;
  assign stall  = load_use & ~branch_taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_v          <= 1'b0;
      ex_branch     <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_alu_src_q  <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_alu_op_q   <= 2'b00;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_rd         <= '0;
    end else if (branch_taken || load_use) begin
      ex_v          <= 1'b0;
      ex_branch     <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_alu_src_q  <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_alu_op_q   <= 2'b00;
      ex_rs1        <= '0;
      ex_rs2        <= '0;
      ex_rd         <= '0;
    end else begin
      ex_v          <= id_valid;
      ex_branch     <= id_branch;
      ex_mem_read   <= id_mem_read;
      // mem_to_reg is a don't-care from the decoder unless the instruction writes a register
      ex_mem_to_reg <= id_mem_to_reg & id_reg_write;
      ex_mem_write  <= id_mem_write;
      ex_alu_src_q  <= id_alu_src;
      ex_reg_write  <= id_reg_write;
      ex_alu_op_q   <= id_alu_op;
      ex_rs1        <= id_rs1;
      ex_rs2        <= id_rs2;
      ex_rd         <= id_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_v           <= 1'b0;
      mem_branch      <= 1'b0;
      mem_mem_read_q  <= 1'b0;
      mem_mem_write_q <= 1'b0;
      mem_mem_to_reg  <= 1'b0;
      mem_reg_write   <= 1'b0;
      mem_zero        <= 1'b0;
      mem_rd          <= '0;
    end else if (branch_taken) begin
      mem_v           <= 1'b0;
      mem_branch      <= 1'b0;
      mem_mem_read_q  <= 1'b0;
      mem_mem_write_q <= 1'b0;
      mem_mem_to_reg  <= 1'b0;
      mem_reg_write   <= 1'b0;
      mem_zero        <= 1'b0;
      mem_rd          <= '0;
    end else begin
      mem_v           <= ex_v;
      mem_branch      <= ex_branch;
      mem_mem_read_q  <= ex_mem_read;
      mem_mem_write_q <= ex_mem_write;
      mem_mem_to_reg  <= ex_mem_to_reg;
      mem_reg_write   <= ex_reg_write;
      mem_zero        <= ex_zero;
      mem_rd          <= ex_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_v            <= 1'b0;
      wb_reg_write_q  <= 1'b0;
      wb_mem_to_reg_q <= 1'b0;
      wb_rd_q         <= '0;
    end else begin
      wb_v            <= mem_v;
      wb_reg_write_q  <= mem_reg_write;
      wb_mem_to_reg_q <= mem_mem_to_reg;
      wb_rd_q         <= mem_rd;
    end
  end

  // MEM is the younger producer, so it is checked ahead of WB.
  always_comb begin
    mem_hit_a = mem_v & mem_reg_write & (mem_rd != '0) & (mem_rd == ex_rs1);
    mem_hit_b = mem_v & mem_reg_write & (mem_rd != '0) & (mem_rd == ex_rs2);
    wb_hit_a  = wb_v & wb_reg_write_q & (wb_rd_q != '0) & (wb_rd_q == ex_rs1);
    wb_hit_b  = wb_v & wb_reg_write_q & (wb_rd_q != '0) & (wb_rd_q == ex_rs2);
    fwd_a     = 2'b00;
    fwd_b     = 2'b00;
    if (ex_v) begin
      if (mem_hit_a)     fwd_a = 2'b10;
      else if (wb_hit_a) fwd_a = 2'b01;
      if (mem_hit_b)     fwd_b = 2'b10;
      else if (wb_hit_b) fwd_b = 2'b01;
    end
  end

  assign ex_alu_op     = ex_v ? ex_alu_op_q : 2'b00;
  assign ex_alu_src    = ex_v & ex_alu_src_q;
  assign mem_mem_read  = mem_v & mem_mem_read_q;
  assign mem_mem_write = mem_v & mem_mem_write_q;
  assign wb_reg_write  = wb_v & wb_reg_write_q;
  assign wb_mem_to_reg = wb_v & wb_mem_to_reg_q;
  assign wb_rd         = wb_v ? wb_rd_q : '0;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// tb/tb_ctrl_pipeline.sv - scoreboard bench for ctrl_pipeline against an instruction-level pipeline model
module tb_ctrl_pipeline;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write;
  logic [1:0] id_alu_op;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       ex_zero;
  logic [1:0] ex_alu_op, fwd_a, fwd_b;
  logic       ex_alu_src, mem_mem_read, mem_mem_write, pc_src, wb_reg_write, wb_mem_to_reg, stall, flush;
  logic [4:0] wb_rd;
  logic [18:0] outv;

  always #5 clk = ~clk;

  ctrl_pipeline #(.REG_AW(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_branch(id_branch), .id_mem_read(id_mem_read),
    .id_mem_to_reg(id_mem_to_reg), .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
    .id_reg_write(id_reg_write), .id_alu_op(id_alu_op), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_zero(ex_zero), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write), .pc_src(pc_src),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_rd(wb_rd), .stall(stall), .flush(flush)
  );

  assign outv = {ex_alu_op, ex_alu_src, fwd_a, fwd_b, mem_mem_read, mem_mem_write, pc_src,
                 wb_reg_write, wb_mem_to_reg, wb_rd, stall, flush};

  typedef struct packed {
    bit       v, br, mrd, m2r, mwr, asrc, rw;
    bit [1:0] op;
    bit [4:0] rs1, rs2, rd;
    bit       z;
  } ins_t;

  // Instructions in flight: index 0 = EX, 1 = MEM, 2 = WB
  ins_t pipe[3];
  ins_t cur_id;
  bit   cur_z, cur_fl, cur_lu;
  logic [18:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic ins_t mk_nop();
    ins_t i = '0;
    return i;
  endfunction

  function automatic ins_t mk_r(bit [4:0] rd, bit [4:0] rs1, bit [4:0] rs2);
    ins_t i = '0;
    i.v = 1; i.rw = 1; i.op = 2'b10; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
    return i;
  endfunction

  function automatic ins_t mk_ld(bit [4:0] rd, bit [4:0] rs1);
    ins_t i = '0;
    i.v = 1; i.mrd = 1; i.m2r = 1; i.rw = 1; i.asrc = 1; i.rd = rd; i.rs1 = rs1;
    return i;
  endfunction

  function automatic ins_t mk_sd(bit [4:0] rs1, bit [4:0] rs2, bit m2r_dc);
    ins_t i = '0;
    i.v = 1; i.mwr = 1; i.asrc = 1; i.m2r = m2r_dc; i.rs1 = rs1; i.rs2 = rs2; i.rd = 5'd9;
    return i;
  endfunction

  function automatic ins_t mk_beq(bit [4:0] rs1, bit [4:0] rs2);
    ins_t i = '0;
    i.v = 1; i.br = 1; i.op = 2'b01; i.rs1 = rs1; i.rs2 = rs2;
    return i;
  endfunction

  // Which older instruction (if any) the EX operand reading register r depends on.
  function automatic bit [1:0] fwd_of(bit [4:0] r);
    if (!pipe[0].v) return 2'b00;
    if (pipe[1].v && pipe[1].rw && pipe[1].rd != 0 && pipe[1].rd == r) return 2'b10;
    if (pipe[2].v && pipe[2].rw && pipe[2].rd != 0 && pipe[2].rd == r) return 2'b01;
    return 2'b00;
  endfunction

  task automatic issue(input ins_t i, input bit z);
    ins_t ex, mem, wb;
    bit fl, lu, reads_rs2;
    id_valid = i.v; id_branch = i.br; id_mem_read = i.mrd; id_mem_to_reg = i.m2r;
    id_mem_write = i.mwr; id_alu_src = i.asrc; id_reg_write = i.rw; id_alu_op = i.op;
    id_rs1 = i.rs1; id_rs2 = i.rs2; id_rd = i.rd; ex_zero = z;
    ex = pipe[0]; mem = pipe[1]; wb = pipe[2];
    fl = mem.v && mem.br && mem.z;
    reads_rs2 = !i.asrc || i.mwr;
    lu = ex.v && ex.mrd && ex.rd != 0 && i.v && (ex.rd == i.rs1 || (reads_rs2 && ex.rd == i.rs2));
    cur_id = i; cur_z = z; cur_fl = fl; cur_lu = lu;
    exp_q.push_back({ex.v ? ex.op : 2'b00, ex.v & ex.asrc, fwd_of(ex.rs1), fwd_of(ex.rs2),
                     mem.v & mem.mrd, mem.v & mem.mwr, fl, wb.v & wb.rw, wb.v & wb.m2r,
                     wb.v ? wb.rd : 5'd0, lu & !fl, fl});
    #2;
  endtask

  task automatic tick();
    ins_t nid;
    @(posedge clk);
    nid = cur_id;
    nid.m2r = cur_id.m2r & cur_id.rw;
    nid.z = 0;
    pipe[2] = pipe[1];
    if (cur_fl) pipe[1] = '0;
    else begin
      pipe[1] = pipe[0];
      pipe[1].z = cur_z;
    end
    pipe[0] = (cur_fl || cur_lu) ? '0 : nid;
    #1;
  endtask

  always @(negedge clk) begin
    logic [18:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (!rst) chk("cycle", 32'(outv), 32'(e));
    end
  end

  initial begin
    ins_t r;
    for (int k = 0; k < 3; k++) pipe[k] = '0;
    cur_id = '0; cur_z = 0; cur_fl = 0; cur_lu = 0;
    rst = 1'b1;
    r = mk_r(5'd3, 5'd1, 5'd2);
    id_valid = r.v; id_branch = 0; id_mem_read = 0; id_mem_to_reg = 0; id_mem_write = 0;
    id_alu_src = 0; id_reg_write = 1; id_alu_op = 2'b10; id_rs1 = 1; id_rs2 = 2; id_rd = 3; ex_zero = 1;
    #3 chk("reset_state", 32'(outv), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // EX/MEM forwarding, then EX/WB forwarding across an independent instruction
    issue(mk_r(5, 1, 2), 0); tick();
    issue(mk_r(6, 7, 5), 0); tick();
    issue(mk_nop(), 0); chk("fwd_b_mem", 32'(fwd_b), 32'd2); tick();
    issue(mk_r(5, 1, 2), 0); tick();
    issue(mk_r(9, 10, 11), 0); tick();
    issue(mk_r(6, 7, 5), 0); tick();
    issue(mk_nop(), 0); chk("fwd_b_wb", 32'(fwd_b), 32'd1); tick();

    // Load-use: one stall cycle, a bubble, then WB forwarding
    issue(mk_ld(5, 1), 0); tick();
    issue(mk_r(6, 5, 7), 0); chk("lu_stall", 32'(stall), 32'd1); tick();
    issue(mk_r(6, 5, 7), 0); chk("lu_stall_once", 32'(stall), 32'd0);
    chk("lu_bubble", 32'({ex_alu_op, ex_alu_src}), 32'd0); tick();
    issue(mk_nop(), 0); chk("lu_fwd_a", 32'(fwd_a), 32'd1); tick();

    // Taken beq: flush one cycle after its EX, squashed followers stay harmless
    issue(mk_beq(1, 2), 0); tick();
    issue(mk_sd(3, 4, 0), 1); chk("br_no_early", 32'(flush), 32'd0); tick();
    issue(mk_r(8, 1, 2), 0); chk("br_pc_src", 32'(pc_src), 32'd1); chk("br_flush", 32'(flush), 32'd1); tick();
    issue(mk_nop(), 0); chk("br_sq_sd", 32'(mem_mem_write), 32'd0); chk("br_flush_once", 32'(flush), 32'd0); tick();
    issue(mk_nop(), 0); chk("br_sq_r_mem", 32'(mem_mem_write), 32'd0); tick();
    issue(mk_nop(), 0); chk("br_sq_r_wb", 32'(wb_reg_write), 32'd0); tick();

    // Not-taken beq
    issue(mk_beq(1, 2), 0); tick();
    issue(mk_sd(3, 4, 0), 0); tick();
    issue(mk_r(8, 1, 2), 0); chk("nt_flush", 32'(flush), 32'd0); tick();
    issue(mk_nop(), 0); chk("nt_sd_mem", 32'(mem_mem_write), 32'd1); tick();

    // Load-use coincident with taken branch
    issue(mk_beq(1, 2), 0); tick();
    issue(mk_ld(5, 1), 1); tick();
    issue(mk_r(6, 5, 7), 0); chk("sf_flush", 32'(flush), 32'd1); chk("sf_stall", 32'(stall), 32'd0); tick();
    issue(mk_nop(), 0); chk("sf_ex_bubble", 32'({ex_alu_op, ex_alu_src}), 32'd0);
    chk("sf_mem_bubble", 32'(mem_mem_read), 32'd0); tick();

    // x0: never a hazard or forward source; sd with don't-care mem_to_reg
    issue(mk_sd(1, 0, 1), 0); tick();
    issue(mk_ld(0, 2), 0); tick();
    issue(mk_r(3, 0, 0), 0); chk("x0_stall", 32'(stall), 32'd0); tick();
    issue(mk_nop(), 0); chk("x0_fwd", 32'({fwd_a, fwd_b}), 32'd0);
    chk("x0_sd_m2r", 32'(wb_mem_to_reg), 32'd0); tick();

    // Asynchronous reset in the middle of an R-type stream
    issue(mk_r(3, 1, 2), 0); tick();
    issue(mk_r(4, 1, 2), 0);
    rst = 1'b1;
    #1 chk("async_rst", 32'(outv), 32'd0);
    @(posedge clk);
    for (int k = 0; k < 3; k++) pipe[k] = '0;
    #1 rst = 1'b0;
    issue(mk_r(3, 1, 2), 0); tick();
    issue(mk_r(4, 3, 2), 0); chk("rst_ex", 32'({ex_alu_op, ex_alu_src}), 32'd4); tick();
    issue(mk_nop(), 0); chk("rst_mem", 32'(fwd_a), 32'd2); tick();
    issue(mk_nop(), 0); chk("rst_wb", 32'({wb_reg_write, wb_rd}), 32'h23); tick();

    // Random instruction mix over a small register set to provoke hazards
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 4))
        0: r = mk_r(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        1: r = mk_ld(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        2: r = mk_sd(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        3: r = mk_beq(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        default: begin
          r.v = 1'($urandom_range(0, 1)); r.br = 1'($urandom_range(0, 1));
          r.mrd = 1'($urandom_range(0, 1)); r.m2r = 1'($urandom_range(0, 1));
          r.mwr = 1'($urandom_range(0, 1)); r.asrc = 1'($urandom_range(0, 1));
          r.rw = 1'($urandom_range(0, 1)); r.op = 2'($urandom_range(0, 3));
          r.rs1 = 5'($urandom_range(0, 7)); r.rs2 = 5'($urandom_range(0, 7));
          r.rd = 5'($urandom_range(0, 7)); r.z = 0;
        end
      endcase
      if ($urandom_range(0, 7) == 0) r.v = 0;
      issue(r, 1'($urandom_range(0, 1)));
      tick();
    end

    issue(mk_nop(), 0); tick();
    issue(mk_nop(), 0); tick();
    @(posedge clk);
    #1 $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_pipeline.md
Name: ctrl_pipeline

Overview:
Consumer-side counterpart of the ID-stage control decoder in the 8-bit RISC-V pipeline. It carries the decoded control bundle through the ID/EX, EX/MEM and MEM/WB stage registers. It also detects load-use hazards, which it resolves by inserting a bubble and stalling, and resolves beq in MEM, which flushes younger instructions. It generates EX-stage forwarding selects and sits between the decoder/register file and the datapath.

Parameters:
REG_AW, 5, register index width (rs1/rs2/rd)

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
id_valid  in  1  ID stage holds a real instruction
id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write  in  1 each  decoder control bundle
id_alu_op  in  2  decoder ALU op
id_rs1, id_rs2, id_rd  in  REG_AW  ID register indices
ex_zero  in  1  ALU zero flag produced in EX this cycle
ex_alu_op  out  2  EX ALU op
ex_alu_src  out  1  EX operand-B select
fwd_a, fwd_b  out  2  EX operand forwarding select: 00 regfile, 10 from MEM, 01 from WB
mem_mem_read, mem_mem_write  out  1  data-memory strobes
pc_src  out  1  take branch target
wb_reg_write, wb_mem_to_reg  out  1  writeback controls
wb_rd  out  REG_AW  writeback destination
stall  out  1  hold PC and IF/ID (combinational)
flush  out  1  clear IF/ID (combinational)

Behaviour:
- State: three stage registers (EX, MEM, WB). Each holds a valid bit, its control subset, rd, and in EX also rs1/rs2. MEM additionally holds the zero flag sampled from ex_zero.
- Reset (async, rst=1): all stage valids and controls are 0 and indices are 0. Every output is therefore 0, including stall, flush and pc_src, and fwd_a/fwd_b are 00.
- Stage controls output only when the stage is valid; an invalid stage drives all-zero controls (a bubble).
- X masking: mem_to_reg is captured as id_mem_to_reg & id_reg_write, so the decoder's don't-care value is never propagated.
- Advance: every cycle WB <= MEM and MEM <= EX, with zero flag <= ex_zero. EX <= ID bundle with valid = id_valid, unless a stall or flush occurs.
- Load-use hazard, combinational:
  - Condition: EX valid, EX mem_read=1, EX rd != 0, and ID valid.
  - Also required: EX rd == id_rs1, or (uses_rs2 and EX rd == id_rs2), where uses_rs2 = !id_alu_src | id_mem_write.
  - Response: stall=1, and EX loads a bubble next edge. MEM/WB advance normally, so the penalty is exactly 1 cycle.
- Branch resolution, combinational:
  - pc_src = flush = MEM valid & MEM branch & MEM zero.
  - Next edge: EX and MEM load bubbles, squashing the instructions currently in ID and EX.
  - Penalty: 3 cycles (the IF/ID clear is done by the datapath on flush).
- Priority: flush overrides stall; when both are true, stall is forced to 0.
- Forwarding, for operand A (fwd_a against EX rs1) and likewise for B (fwd_b against EX rs2):
  - 10 if MEM valid & MEM reg_write & MEM rd != 0 & MEM rd == EX rs1.
  - Else 01 if WB valid & WB reg_write & WB rd != 0 & WB rd == EX rs1.
  - Else 00. MEM has priority over WB.
  - Both selects are forced to 00 when EX is invalid.
- Register x0 never triggers a hazard or forwarding.
- Reset mid-operation clears all stages immediately, regardless of clk; no in-flight writeback completes.

Test Plan:
- Reset during a stream of valid R-types.
  - Required: all outputs 0 asynchronously before the next edge.
  - After release, the first R-type (reg_write=1, alu_op=10) appears in EX one cycle, MEM two cycles and WB three cycles after ID presentation.
- ld x5 followed by add x6,x5,x7.
  - Required: stall=1 for exactly one cycle and a bubble in EX (ex_alu_op=00, all controls 0).
  - Then, with the add in EX: fwd_a=01 (from WB).
- add x5 followed by sub x6,x7,x5.
  - Required: fwd_b=10 with the sub in EX.
  - Repeat with one independent instruction between the two: fwd_b=01.
- beq with ex_zero=1 in its EX cycle.
  - Required: pc_src=flush=1 exactly one cycle later.
  - The next two younger instructions never reach MEM with mem_write/reg_write set.
  - Repeat with ex_zero=0: no flush.
- Load-use stall condition coincident with a taken branch in MEM.
  - Required: flush=1, stall=0, EX and MEM bubbles.
- sd writing x0 and ld into x0 followed by a use of x0.
  - Required: stall=0, fwd=00, and wb_mem_to_reg=0 for the sd even if id_mem_to_reg=X.
